// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode codes, issue FSM states
// and the signed-overflow sign rule.
package alu_pkg;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Sign rule on the three msbs. A subtract flips b's
  // sign, so the operand-sign test inverts for SUB.
  function automatic logic sgn_ovf(
    input logic mode,
    input logic am,
    input logic bm,
    input logic cm
  );
    logic same;
    same = (am == bm);
    if (mode == ALU_SUB) begin
      return !same && (cm != am);
    end
    return same && (cm != am);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ADD/SUB datapath.
// Ports: a_i, b_i, mode_i in; c_o (wrapped), ovf_o out.
module alu
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  input  logic                 mode_i,
  output logic [WORD_SIZE-1:0] c_o,
  output logic                 ovf_o
);

  localparam int W = WORD_SIZE;

  logic [W:0] ax;
  logic [W:0] bx;
  logic [W:0] sx;

  // One guard bit: overflow when the guard and msb disagree.
  assign ax = {a_i[W-1], a_i};
  assign bx = {b_i[W-1], b_i};

  always_comb begin
    sx = ax + bx;
    if (mode_i == ALU_SUB) begin
      sx = ax - bx;
    end
  end

  assign c_o   = sx[W-1:0];
  assign ovf_o = sx[W] ^ sx[W-1];

endmodule

// File: rtl/alu_issue.sv
// Sequential initiator for alu: req -> EXEC -> rsp handshake.
// Ports: req_* in/req_ready out, rsp_* out/rsp_ready in, ovf_sticky, op_count.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_SIZE-1:0] req_a,
  input  logic [WORD_SIZE-1:0] req_b,
  input  logic                 req_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_c,
  output logic                 rsp_ovf,
  output logic                 ovf_sticky,
  input  logic                 ovf_clear,
  output logic [15:0]          op_count
);

  localparam int W = WORD_SIZE;

  state_e      state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] c_q, c_d;
  logic        mode_q, mode_d;
  logic        ovf_q, ovf_d;
  logic        stk_q, stk_d;
  logic [15:0] cnt_q, cnt_d;
  logic [W-1:0] alu_c;
  logic        alu_ovf;
  logic        ovf_now;

  alu #(
    .WORD_SIZE(W)
  ) u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .mode_i(mode_q),
    .c_o   (alu_c),
    .ovf_o (alu_ovf)
  );

  assign ovf_now = sgn_ovf(mode_q, a_q[W-1],
                           b_q[W-1], alu_c[W-1]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    stk_d   = stk_q & ~ovf_clear;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          mode_d  = req_mode;
          state_d = EXEC;
        end
      end
      EXEC: begin
        c_d   = alu_c;
        ovf_d = ovf_now;
        // Set overrides a same-cycle clear.
        if (ovf_now) stk_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= ALU_ADD;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      stk_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_c      = c_q;
  assign rsp_ovf    = ovf_q;
  assign ovf_sticky = stk_q;
  assign op_count   = cnt_q;

  // The sign rule and the alu's guard-bit flag must agree.
  a_ovf_agree: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == EXEC) |-> (alu_ovf == ovf_now)
  );

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue (W=8).
// Drives on negedge, samples on negedge before driving.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_mode;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_c;
  logic       rsp_ovf;
  logic       ovf_sticky;
  logic       ovf_clear;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_stk = 1'b0;

  always #5 clk = ~clk;

  alu_issue #(
    .WORD_SIZE(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_ovf   (rsp_ovf),
    .ovf_sticky(ovf_sticky),
    .ovf_clear (ovf_clear),
    .op_count  (op_count)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction with rsp_ready high; starts and
  // ends on a negedge in IDLE. clr drives ovf_clear
  // during the EXEC cycle.
  task automatic run_op(
    input string      tag,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       m,
    input logic [7:0] ec,
    input logic       eo,
    input logic       clr
  );
    chk({tag, "_rdy"}, req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_mode  = m;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    ovf_clear = clr;
    chk({tag, "_exec_vld"}, rsp_valid, 0);
    tick();
    ovf_clear = 1'b0;
    if (eo) exp_stk = 1'b1;
    else if (clr) exp_stk = 1'b0;
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_c"}, rsp_c, ec);
    chk({tag, "_ovf"}, rsp_ovf, eo);
    chk({tag, "_stk"}, ovf_sticky, exp_stk);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, "_cnt"}, op_count, exp_cnt);
    chk({tag, "_idle"}, req_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = 8'd0;
    req_b     = 8'd0;
    req_mode  = 1'b0;
    rsp_ready = 1'b0;
    ovf_clear = 1'b0;
    tick();
    tick();
    chk("rst_rdy", req_ready, 1);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_c", rsp_c, 0);
    chk("rst_ovf", rsp_ovf, 0);
    chk("rst_stk", ovf_sticky, 0);
    chk("rst_cnt", op_count, 0);
    rst_n = 1'b1;

    // Reset while in EXEC discards the operation.
    req_valid = 1'b1;
    req_a     = 8'd7;
    req_b     = 8'd9;
    req_mode  = 1'b0;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("mid_exec_rdy", req_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_rdy", req_ready, 1);
    chk("mid_rst_vld", rsp_valid, 0);
    chk("mid_rst_cnt", op_count, 0);
    tick();
    chk("mid_after_vld", rsp_valid, 0);
    chk("mid_after_cnt", op_count, 0);

    run_op("add5_3", 8'd5, 8'd3, 1'b0, 8'd8, 1'b0, 1'b0);
    run_op("add100", 8'd100, 8'd100, 1'b0, 8'hC8, 1'b1, 1'b0);
    run_op("sub10_3", 8'd10, 8'd3, 1'b1, 8'd7, 1'b0, 1'b0);
    run_op("sub0_min", 8'h00, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0);
    run_op("submin_1", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0);
    run_op("addmin_m1", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b0);

    // Backpressure: hold RESP for 5 cycles.
    req_valid = 1'b1;
    req_a     = 8'd1;
    req_b     = 8'd2;
    req_mode  = 1'b0;
    rsp_ready = 1'b0;
    tick();
    req_a = 8'd50;
    req_b = 8'd60;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", rsp_valid, 1);
      chk("bp_c", rsp_c, 8'd3);
      chk("bp_ovf", rsp_ovf, 0);
      chk("bp_rdy", req_ready, 0);
      chk("bp_cnt", op_count, exp_cnt);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_rel_vld", rsp_valid, 0);
    chk("bp_rel_rdy", req_ready, 1);
    chk("bp_rel_cnt", op_count, exp_cnt);
    tick();
    chk("bp_no_acc", req_ready, 1);
    chk("bp_cnt_hold", op_count, exp_cnt);

    // Clear alone, then clear racing an overflow.
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    exp_stk = 1'b0;
    chk("clr_alone", ovf_sticky, 0);
    run_op("clr_race", 8'd100, 8'd100, 1'b0, 8'hC8, 1'b1, 1'b1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("clr_after", ovf_sticky, 0);
    exp_stk = 1'b0;

    // Counter wrap from a preloaded 0xFFFF.
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    chk("pre_cnt", op_count, 16'hFFFF);
    run_op("wrap", 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
